// File: rtl/pmod_ctrl_axil_master.sv
// AXI4-Lite initiator for the Pmod switchbox control port.
// Turns one local read/write command into one AXI4-Lite transaction and
// hands back the read data and response code. Only one transaction is in
// flight at a time.
module pmod_ctrl_axil_master #(
    parameter int          ADDR_W = 8,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_write,

    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_awvalid,
    input  logic                m_awready,

    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,

    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,

    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    output logic                m_arvalid,
    input  logic                m_arready,

    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done;
    logic                w_done;

    // Address and data payloads come straight from the captured command so they hold between transactions
    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;
    assign m_awprot = PROT;
    assign m_arprot = PROT;

    // State register; reset returns to IDLE from anywhere, abandoning any transaction in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; valids are decoded from registered state only, never from a ready
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    state_next = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
                if ((aw_done || m_awready) && (w_done || m_wready)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_next = RESP;
                end
            end
            RD_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture, per-channel write handshake tracking and response latching
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            rsp_write <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_ADDR_DATA && m_awvalid && m_awready) begin
                aw_done <= 1'b1;
            end
            if (state == WR_ADDR_DATA && m_wvalid && m_wready) begin
                w_done <= 1'b1;
            end
            if (state == WR_RESP && m_bvalid) begin
                rsp_resp  <= m_bresp;
                rsp_rdata <= '0;
                rsp_write <= 1'b1;
            end
            if (state == RD_DATA && m_rvalid) begin
                rsp_resp  <= m_rresp;
                rsp_rdata <= m_rdata;
                rsp_write <= 1'b0;
            end
        end
    end

endmodule
